funnel_feed_aligner: RTL and testbench

FUNNEL_FEED_ALIGNER -- requirements
Module: funnel_feed_aligner

---
 rtl/funnel_feed_aligner.sv | 180 ++++++++++++++++++
 tb/tb_funnel_feed_aligner.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/funnel_feed_aligner.sv
// Funnel-feed aligner: finds a 10-bit sync pattern at any bit offset in a raw
// word stream. It verifies and locks onto that offset, then feeds a left funnel
// shifter with the registered word pair and the shift amount.
module funnel_feed_aligner #(
  parameter logic [9:0]  SYNC       = 10'b0011111010,
  parameter int unsigned VERIFY_CNT = 3,
  parameter int unsigned LOSS_WIN   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] in_data,
  input  logic       in_valid,
  output logic [9:0] fs_hi,
  output logic [9:0] fs_lo,
  output logic [3:0] fs_amt,
  output logic       fs_valid,
  output logic       locked,
  output logic       sync_hit
);

  localparam int unsigned DW = 10;
  localparam int unsigned AW = 4;
  localparam int unsigned HW = (VERIFY_CNT < 2) ? 1 : $clog2(VERIFY_CNT + 1);
  localparam int unsigned LW = (LOSS_WIN < 2) ? 1 : $clog2(LOSS_WIN + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_prev;
  logic          r_have_prev;
  logic [AW-1:0] r_offset;
  logic [HW-1:0] r_hit_cnt;
  logic [LW-1:0] r_win_cnt;
  logic [DW-1:0] r_fs_hi;
  logic [DW-1:0] r_fs_lo;
  logic [AW-1:0] r_fs_amt;
  logic          r_fs_valid;
  logic          r_locked;
  logic          r_sync_hit;

  logic [2*DW-1:0] w_window;
  logic [15:0]     w_match;
  logic            w_any;
  logic [AW-1:0]   w_cand;
  logic            w_hit_at_off;
  logic [AW-1:0]   w_nxt_offset;
  logic            w_verify_done;
  logic            w_loss;

  assign w_window = {r_prev, in_data};

  // Pattern match at every bit offset of the 20-bit window; upper bits pad to zero
  always_comb begin
    w_match = '0;
    for (int k = 0; k < DW; k++) begin
      w_match[k] = (w_window[(2*DW-1-k) -: DW] == SYNC);
    end
  end

  // Lowest matching offset is the candidate
  always_comb begin
    w_cand = '0;
    for (int k = DW - 1; k >= 0; k--) begin
      if (w_match[k]) w_cand = AW'(k);
    end
  end

  assign w_any         = |w_match;
  assign w_hit_at_off  = w_match[r_offset];
  assign w_verify_done = (32'(r_hit_cnt) + 32'd1) >= VERIFY_CNT;
  assign w_loss        = (32'(r_win_cnt) + 32'd1) >= LOSS_WIN;

  // Offset after this word: HUNT takes any candidate, VERIFY retargets only
  // when the held offset misses, LOCKED never moves
  always_comb begin
    w_nxt_offset = r_offset;
    case (r_state)
      HUNT:    if (w_any) w_nxt_offset = w_cand;
      VERIFY:  if (!w_hit_at_off && w_any) w_nxt_offset = w_cand;
      default: w_nxt_offset = r_offset;
    endcase
  end

  // Alignment FSM, counters, word history and registered shifter feed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= HUNT;
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_offset    <= '0;
      r_hit_cnt   <= '0;
      r_win_cnt   <= '0;
      r_fs_hi     <= '0;
      r_fs_lo     <= '0;
      r_fs_amt    <= '0;
      r_fs_valid  <= 1'b0;
      r_locked    <= 1'b0;
      r_sync_hit  <= 1'b0;
    end else begin
      r_fs_valid <= 1'b0;
      r_sync_hit <= 1'b0;
      if (in_valid) begin
        r_prev      <= in_data;
        r_have_prev <= 1'b1;
        if (r_have_prev) begin
          r_fs_hi    <= r_prev;
          r_fs_lo    <= in_data;
          r_fs_amt   <= w_nxt_offset;
          r_fs_valid <= 1'b1;
          r_sync_hit <= w_match[w_nxt_offset];
          r_offset   <= w_nxt_offset;
          case (r_state)
            HUNT: begin
              if (w_any) begin
                r_hit_cnt <= HW'(1);
                r_win_cnt <= '0;
                if (VERIFY_CNT <= 1) begin
                  r_state  <= LOCKED;
                  r_locked <= 1'b1;
                end else begin
                  r_state <= VERIFY;
                end
              end
            end
            VERIFY: begin
              if (w_hit_at_off) begin
                r_win_cnt <= '0;
                if (w_verify_done) begin
                  r_hit_cnt <= HW'(VERIFY_CNT);
                  r_state   <= LOCKED;
                  r_locked  <= 1'b1;
                end else begin
                  r_hit_cnt <= r_hit_cnt + HW'(1);
                end
              end else if (w_any) begin
                r_hit_cnt <= HW'(1);
                r_win_cnt <= '0;
              end else if (w_loss) begin
                r_win_cnt <= LW'(LOSS_WIN);
                r_hit_cnt <= '0;
                r_state   <= HUNT;
                r_locked  <= 1'b0;
              end else begin
                r_win_cnt <= r_win_cnt + LW'(1);
              end
            end
            LOCKED: begin
              if (w_hit_at_off) begin
                r_win_cnt <= '0;
              end else if (w_loss) begin
                r_win_cnt <= LW'(LOSS_WIN);
                r_hit_cnt <= '0;
                r_state   <= HUNT;
                r_locked  <= 1'b0;
              end else begin
                r_win_cnt <= r_win_cnt + LW'(1);
              end
            end
            default: begin
              r_state  <= HUNT;
              r_locked <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign fs_hi    = r_fs_hi;
  assign fs_lo    = r_fs_lo;
  assign fs_amt   = r_fs_amt;
  assign fs_valid = r_fs_valid;
  assign locked   = r_locked;
  assign sync_hit = r_sync_hit;

endmodule

// File: tb/tb_funnel_feed_aligner.sv
// Directed bench for funnel_feed_aligner: hand-computed vectors for reset,
// first-word behaviour, acquisition, lock, loss, retargeting and lowest-offset priority.
module tb_funnel_feed_aligner;

  localparam logic [9:0] SYNC = 10'b0011111010;
  localparam logic [9:0] A    = 10'b0000011111;
  localparam logic [9:0] B    = 10'b0100000000;
  localparam logic [9:0] DUAL = 10'b0111110100;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] in_data;
  logic       in_valid;
  logic [9:0] fs_hi;
  logic [9:0] fs_lo;
  logic [3:0] fs_amt;
  logic       fs_valid;
  logic       locked;
  logic       sync_hit;

  int n_checks = 0;
  int n_errors = 0;

  funnel_feed_aligner dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .fs_hi    (fs_hi),
    .fs_lo    (fs_lo),
    .fs_amt   (fs_amt),
    .fs_valid (fs_valid),
    .locked   (locked),
    .sync_hit (sync_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge, sample 1 time unit after the rising edge
  task automatic step(input logic r, input logic [9:0] d, input logic v);
    @(negedge clk);
    rst      = r;
    in_data  = d;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hi"},    32'(fs_hi),    32'd0);
    chk({tag, "_lo"},    32'(fs_lo),    32'd0);
    chk({tag, "_amt"},   32'(fs_amt),   32'd0);
    chk({tag, "_valid"}, 32'(fs_valid), 32'd0);
    chk({tag, "_lock"},  32'(locked),   32'd0);
    chk({tag, "_hit"},   32'(sync_hit), 32'd0);
  endtask

  function automatic logic [9:0] aligned(input logic [9:0] hi, input logic [9:0] lo,
                                         input logic [3:0] amt);
    logic [19:0] t;
    t = {hi, lo} << amt;
    return t[19:10];
  endfunction

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0;

    // Reset state
    step(1'b1, 10'h000, 1'b0);
    step(1'b1, 10'h000, 1'b0);
    chk_all_zero("reset");

    // First word after reset yields nothing
    step(1'b0, 10'h155, 1'b1);
    chk_all_zero("first_word");

    // Reset overrides in_valid and clears history
    step(1'b1, A, 1'b1);
    chk_all_zero("rst_override");

    // Acquire: A,B puts SYNC at offset 3
    step(1'b0, A, 1'b1);
    chk("ab_first_valid", 32'(fs_valid), 32'd0);
    step(1'b0, B, 1'b1);
    chk("ab_valid", 32'(fs_valid), 32'd1);
    chk("ab_hi",    32'(fs_hi),    32'(A));
    chk("ab_lo",    32'(fs_lo),    32'(B));
    chk("ab_amt",   32'(fs_amt),   32'd3);
    chk("ab_hit",   32'(sync_hit), 32'd1);
    chk("ab_lock",  32'(locked),   32'd0);
    chk("ab_align", 32'(aligned(fs_hi, fs_lo, fs_amt)), 32'(SYNC));

    step(1'b0, A, 1'b1);
    chk("w3_hit",  32'(sync_hit), 32'd0);
    chk("w3_amt",  32'(fs_amt),   32'd3);
    step(1'b0, B, 1'b1);
    chk("w4_hit",  32'(sync_hit), 32'd1);
    chk("w4_lock", 32'(locked),   32'd0);
    step(1'b0, A, 1'b1);
    chk("w5_lock", 32'(locked),   32'd0);
    step(1'b0, B, 1'b1);
    chk("w6_lock", 32'(locked),   32'd1);
    chk("w6_amt",  32'(fs_amt),   32'd3);

    // Idle cycle: no valid, outputs and state hold
    step(1'b0, 10'h3ff, 1'b0);
    chk("idle_valid", 32'(fs_valid), 32'd0);
    chk("idle_hi",    32'(fs_hi),    32'(A));
    chk("idle_lo",    32'(fs_lo),    32'(B));
    chk("idle_amt",   32'(fs_amt),   32'd3);
    chk("idle_lock",  32'(locked),   32'd1);

    // Loss window: 63 misses keep lock, the 64th drops it
    for (int i = 0; i < 63; i++) begin
      step(1'b0, 10'h000, 1'b1);
      chk("loss_lock", 32'(locked),   32'd1);
      chk("loss_amt",  32'(fs_amt),   32'd3);
      chk("loss_hit",  32'(sync_hit), 32'd0);
    end
    step(1'b0, 10'h000, 1'b1);
    chk("loss64_lock", 32'(locked), 32'd0);
    chk("loss64_amt",  32'(fs_amt), 32'd3);

    // Re-acquire at offset 3 into VERIFY, then retarget to offset 0
    step(1'b0, A, 1'b1);
    chk("re_a_hit", 32'(sync_hit), 32'd0);
    step(1'b0, B, 1'b1);
    chk("re_b_amt", 32'(fs_amt),   32'd3);
    chk("re_b_hit", 32'(sync_hit), 32'd1);
    step(1'b0, SYNC, 1'b1);
    chk("rt_s_hit", 32'(sync_hit), 32'd0);
    step(1'b0, 10'h000, 1'b1);
    chk("rt_amt",   32'(fs_amt),   32'd0);
    chk("rt_hit",   32'(sync_hit), 32'd1);
    chk("rt_lock",  32'(locked),   32'd0);
    chk("rt_align", 32'(aligned(fs_hi, fs_lo, fs_amt)), 32'(SYNC));
    // Count restarted at 1: second hit must not lock, third must
    step(1'b0, SYNC, 1'b1);
    step(1'b0, 10'h000, 1'b1);
    chk("rt2_lock", 32'(locked), 32'd0);
    chk("rt2_amt",  32'(fs_amt), 32'd0);
    step(1'b0, SYNC, 1'b1);
    step(1'b0, 10'h000, 1'b1);
    chk("rt3_lock", 32'(locked), 32'd1);
    chk("rt3_amt",  32'(fs_amt), 32'd0);

    // LOCKED ignores a hit at a different offset
    step(1'b0, A, 1'b1);
    step(1'b0, B, 1'b1);
    chk("ign_amt",  32'(fs_amt),   32'd0);
    chk("ign_hit",  32'(sync_hit), 32'd0);
    chk("ign_lock", 32'(locked),   32'd1);

    // Reset while locked with in_valid high
    step(1'b1, A, 1'b1);
    chk_all_zero("rst_locked");
    step(1'b0, SYNC, 1'b1);
    chk("post_rst_valid", 32'(fs_valid), 32'd0);
    chk("post_rst_lock",  32'(locked),   32'd0);

    // Matches at offsets 0 and 9 together: lowest wins
    step(1'b0, DUAL, 1'b1);
    chk("dual_valid", 32'(fs_valid), 32'd1);
    chk("dual_amt",   32'(fs_amt),   32'd0);
    chk("dual_hit",   32'(sync_hit), 32'd1);
    chk("dual_align", 32'(aligned(fs_hi, fs_lo, fs_amt)), 32'(SYNC));

    step(1'b0, 10'h000, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
